// File: rtl/encoder_8to3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// The requester drives en/a; the encoder returns registered y/valid/multi.
interface encoder_8to3_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
);
    logic             en;
    logic [IN_W-1:0]  a;
    logic [OUT_W-1:0] y;
    logic             valid;
    logic             multi;

    modport master (
        output en,
        output a,
        input  y,
        input  valid,
        input  multi
    );

    modport slave (
        input  en,
        input  a,
        output y,
        output valid,
        output multi
    );
endinterface

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder: highest set bit wins,
// with valid (any bit set) and multi (two or more bits set) flags.
module encoder_8to3 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    encoder_8to3_if.slave  bus
);

    logic [OUT_W-1:0] hi_idx;
    logic             any_set;
    logic             multi_hot;

    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;
    logic             valid_d;
    logic             valid_q;
    logic             multi_d;
    logic             multi_q;

    // Ascending scan so the highest set bit is the last to assign.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (bus.a[i]) begin
                hi_idx = OUT_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any_set   = |bus.a;
        multi_hot = |(bus.a & (bus.a - IN_W'(1)));
    end

    always_comb begin
        y_d     = '0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (bus.en) begin
            y_d     = hi_idx;
            valid_d = any_set;
            multi_d = multi_hot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3: directed cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_encoder_8to3;

    logic clk;
    logic rst;

    int tests;
    int fails;

    logic [4:0] exp_q;

    encoder_8to3_if #(.IN_W(8), .OUT_W(3)) bus ();

    encoder_8to3 #(.IN_W(8), .OUT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packed as {y, valid, multi}.
    function automatic logic [4:0] model(logic e, logic [7:0] v);
        int         idx;
        int         ones;
        logic [7:0] t;
        idx = 0;
        t   = v;
        if (!e) return 5'd0;
        while (t > 8'd1) begin
            t = t >> 1;
            idx++;
        end
        ones = $countones(v);
        return {idx[2:0], v != 8'd0, ones >= 2};
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got y=%0d valid=%0b multi=%0b, expected y=%0d valid=%0b multi=%0b",
                     name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [4:0] dut_out();
        return {bus.y, bus.valid, bus.multi};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 5'd0;
        else     exp_q <= model(bus.en, bus.a);
    end

    always @(negedge clk) begin
        check("model", dut_out(), exp_q);
    end

    task automatic drive(logic e, logic [7:0] v);
        @(negedge clk);
        bus.en = e;
        bus.a  = v;
    endtask

    task automatic lit(string name, logic [2:0] y, logic v, logic m);
        @(posedge clk);
        #1;
        check(name, dut_out(), {y, v, m});
    endtask

    initial begin
        logic [7:0] v;
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        bus.en = 1'b1;
        bus.a  = 8'h80;

        // Reset acts without any clock edge.
        #2 rst = 1'b1;
        #1 check("reset_async", dut_out(), 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lit("reset_release", 3'd7, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFF);
            lit("en_low", 3'd0, 1'b0, 1'b0);
        end

        drive(1'b1, 8'h00);
        lit("zero_in", 3'd0, 1'b0, 1'b0);
        drive(1'b1, 8'h01);
        lit("bit0", 3'd0, 1'b1, 1'b0);

        for (int i = 1; i < 8; i++) begin
            v = 8'h01 << i;
            drive(1'b1, v);
            lit("onehot", 3'(i), 1'b1, 1'b0);
        end

        drive(1'b1, 8'b0010_0110);
        lit("multi_26", 3'd5, 1'b1, 1'b1);
        drive(1'b1, 8'hFF);
        lit("multi_ff", 3'd7, 1'b1, 1'b1);
        drive(1'b1, 8'h03);
        lit("multi_03", 3'd1, 1'b1, 1'b1);

        // Reset between edges while a sample is pending.
        drive(1'b1, 8'h40);
        lit("stream_40", 3'd6, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check("mid_reset", dut_out(), 5'd0);
        #1 rst = 1'b0;
        lit("after_reset", 3'd6, 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            bus.en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       bus.a = 8'h01 << $urandom_range(0, 7);
                1:       bus.a = 8'h00;
                default: bus.a = 8'($urandom);
            endcase
        end

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
